// File: rtl/link_speed_detect.sv
// Link-speed classifier for the RGMII MAC: times the divided rx clock against the
// 125 MHz reference, classifies 10M/100M/1G with hysteresis and tracks link presence.
module link_speed_detect #(
  parameter int CNT_WIDTH      = 12,
  parameter int MEAS_EDGES     = 2,
  parameter int THRESH_1G      = 16,
  parameter int THRESH_100M    = 128,
  parameter int TIMEOUT_CYCLES = 4000,
  parameter int STABLE_CNT     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 rxc_div,
  output logic [1:0]           link_speed,
  output logic                 mii_sel,
  output logic                 link_up,
  output logic                 speed_change,
  output logic [CNT_WIDTH-1:0] period_cnt,
  output logic                 meas_valid
);

  localparam int STAB_W = (STABLE_CNT < 2) ? 1 : $clog2(STABLE_CNT + 1);
  localparam int EDGE_W = (MEAS_EDGES < 2) ? 1 : $clog2(MEAS_EDGES + 1);

  typedef enum logic [0:0] {
    SYNC    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t               state_r;
  logic                 rxc_q_r;
  logic [CNT_WIDTH-1:0] ref_cnt_r;
  logic [EDGE_W-1:0]    edge_cnt_r;
  logic [1:0]           cand_r;
  logic [STAB_W-1:0]    stab_r;

  logic                 edge_s;
  logic                 close_s;
  logic                 timeout_s;
  logic [1:0]           cls_s;
  logic [STAB_W-1:0]    stab_next_s;
  logic                 commit_s;

  function automatic logic [1:0] classify(input logic [CNT_WIDTH-1:0] p);
    if (p < CNT_WIDTH'(THRESH_1G)) begin
      classify = 2'b10;
    end else if (p < CNT_WIDTH'(THRESH_100M)) begin
      classify = 2'b01;
    end else begin
      classify = 2'b00;
    end
  endfunction

  // Edge, closing-edge and timeout detection plus next hysteresis count
  always_comb begin
    edge_s    = rxc_div ^ rxc_q_r;
    close_s   = (state_r == MEASURE) && edge_s &&
                (edge_cnt_r == EDGE_W'(MEAS_EDGES - 1));
    // A closing edge arriving on the timeout cycle still counts as a measurement
    timeout_s = (state_r == MEASURE) && !close_s &&
                (ref_cnt_r == CNT_WIDTH'(TIMEOUT_CYCLES));
    cls_s     = classify(ref_cnt_r);
    if (cls_s == cand_r) begin
      if (stab_r == STAB_W'(STABLE_CNT)) begin
        stab_next_s = stab_r;
      end else begin
        stab_next_s = stab_r + STAB_W'(1'b1);
      end
    end else begin
      stab_next_s = STAB_W'(1'b1);
    end
    commit_s = (stab_next_s == STAB_W'(STABLE_CNT));
  end

  // Measurement FSM, hysteresis and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= SYNC;
      rxc_q_r      <= 1'b0;
      ref_cnt_r    <= '0;
      edge_cnt_r   <= '0;
      cand_r       <= 2'b00;
      stab_r       <= '0;
      link_speed   <= 2'b10;
      link_up      <= 1'b0;
      speed_change <= 1'b0;
      period_cnt   <= '0;
      meas_valid   <= 1'b0;
    end else begin
      rxc_q_r      <= rxc_div;
      meas_valid   <= 1'b0;
      speed_change <= 1'b0;
      if (!enable) begin
        state_r    <= SYNC;
        ref_cnt_r  <= '0;
        edge_cnt_r <= '0;
        cand_r     <= 2'b00;
        stab_r     <= '0;
      end else begin
        case (state_r)
          SYNC: begin
            edge_cnt_r <= '0;
            if (edge_s) begin
              // ref_cnt is 0 in the opening cycle, so it reads 1 one cycle later
              state_r   <= MEASURE;
              ref_cnt_r <= CNT_WIDTH'(1'b1);
            end else begin
              ref_cnt_r <= '0;
            end
          end
          MEASURE: begin
            if (close_s) begin
              ref_cnt_r  <= CNT_WIDTH'(1'b1);
              edge_cnt_r <= '0;
              period_cnt <= ref_cnt_r;
              meas_valid <= 1'b1;
              cand_r     <= cls_s;
              stab_r     <= stab_next_s;
              if (commit_s) begin
                link_up      <= 1'b1;
                link_speed   <= cls_s;
                speed_change <= (cls_s != link_speed);
              end
            end else if (timeout_s) begin
              state_r    <= SYNC;
              ref_cnt_r  <= '0;
              edge_cnt_r <= '0;
              link_up    <= 1'b0;
              cand_r     <= 2'b00;
              stab_r     <= '0;
            end else begin
              ref_cnt_r <= ref_cnt_r + CNT_WIDTH'(1'b1);
              if (edge_s) begin
                edge_cnt_r <= edge_cnt_r + EDGE_W'(1'b1);
              end
            end
          end
          default: begin
            state_r    <= SYNC;
            ref_cnt_r  <= '0;
            edge_cnt_r <= '0;
          end
        endcase
      end
    end
  end

  assign mii_sel = (link_speed != 2'b10);

endmodule

// File: doc/link_speed_detect.md
Name: link_speed_detect

Overview:
- Parametrised link-speed classifier for the RGMII MAC. It runs in the 125 MHz clock domain and measures the period of a divided, already-synchronised receive-clock level (`rxc_div`).
- It classifies the link as 10M, 100M or 1G using configurable thresholds. A new speed is committed only after N consecutive agreeing measurements (hysteresis).
- It detects loss of the receive clock and reports `link_up`, speed-change events and the raw period measurement.
- It drives `link_speed` / `mii_sel` consumed by the tx/rx MACs and the RGMII interface.

Parameters:
CNT_WIDTH, 12, width of the reference period counter and of `period_cnt`.
MEAS_EDGES, 2, `rxc_div` edges after the opening edge that close one measurement (2 = one full period).
THRESH_1G, 16, measured period < THRESH_1G classifies as 1G (2'b10).
THRESH_100M, 128, THRESH_1G <= period < THRESH_100M classifies as 100M (2'b01); otherwise 10M (2'b00).
TIMEOUT_CYCLES, 4000, cycles without a closing edge before the link is declared down; must be < 2^CNT_WIDTH.
STABLE_CNT, 2, consecutive identical classifications required to commit a speed (>=1).

Ports:
clk  in  1  125 MHz reference clock
reset_n  in  1  reset; asynchronous, active-low
enable  in  1  measurement enable; low aborts the current measurement and holds the outputs
rxc_div  in  1  divided rx clock level, already synchronised to clk
link_speed  out  2  committed speed: 00 = 10M, 01 = 100M, 10 = 1G
mii_sel  out  1  1 when link_speed != 2'b10
link_up  out  1  receive clock present and speed committed
speed_change  out  1  1-cycle pulse when link_speed changes value
period_cnt  out  CNT_WIDTH  last measured period in clk cycles
meas_valid  out  1  1-cycle pulse when period_cnt is updated

Behaviour:
- Reset (asynchronous, immediate): link_speed=2'b10, mii_sel=0, link_up=0, speed_change=0, period_cnt=0, meas_valid=0, FSM=SYNC, all counters and the candidate cleared.
- Edge detect: rxc_div is registered once into rxc_q; edge = rxc_div ^ rxc_q. Both rising and falling edges count.
- SYNC state:
  - ref_cnt and edge_cnt are held at 0.
  - On the first edge with enable=1 -> MEASURE. That edge is the opening edge; ref_cnt=0 in that cycle.
- MEASURE state:
  - ref_cnt increments every cycle.
  - Each edge increments edge_cnt.
  - The edge that makes edge_cnt reach MEAS_EDGES is the closing edge. It captures P = cycle distance between the opening-edge and closing-edge detect cycles.
  - The closing edge becomes the opening edge of the next measurement: ref_cnt restarts at 0, edge_cnt=0, FSM stays in MEASURE.
  - Cycle after the closing edge: period_cnt=P, meas_valid=1 for 1 cycle.
- Classification: P<THRESH_1G -> 10; P<THRESH_100M -> 01; else 00.
- Hysteresis:
  - If the classification equals the stored candidate, stab_cnt increments (saturating); otherwise candidate=classification and stab_cnt=1.
  - When stab_cnt reaches STABLE_CNT: link_up=1 and link_speed=candidate, in the same cycle as meas_valid.
  - speed_change=1 in that same cycle only if link_speed differs from its previous value.
  - mii_sel is derived from the registered link_speed; no extra latency.
- Timeout: in MEASURE, when ref_cnt == TIMEOUT_CYCLES with no closing edge:
  - link_up=0, FSM -> SYNC, candidate and stab_cnt cleared.
  - link_speed is held; no meas_valid, no speed_change.
- Simultaneous closing edge and timeout in the same cycle: the edge wins and a normal measurement is taken.
- enable low:
  - FSM -> SYNC next cycle; the measurement in progress is discarded (no meas_valid).
  - candidate and stab_cnt cleared; link_speed, link_up and period_cnt are held.
- ref_cnt never wraps; it is bounded by TIMEOUT_CYCLES.
- Reset asserted mid-measurement: all state returns to reset values immediately. After release the next edge is treated as an opening edge.

Test Plan:
1. Reset release, enable=1, rxc_div toggles every 4 clk -> meas_valid with period_cnt=8 each measurement. After the 2nd: link_up=1, link_speed=10, mii_sel=0, speed_change never pulses.
2. Toggle every 20 clk -> period_cnt=40. On the 2nd meas_valid: link_speed=01, mii_sel=1, speed_change exactly one 1-cycle pulse.
3. Toggle every 200 clk -> period_cnt=400, link_speed=00 after 2 measurements. Then toggle every 4 clk -> returns to 10 after 2 measurements, with one speed_change pulse.
4. Alternate half-periods producing P=40, 8, 40, 8 -> meas_valid each time, link_speed and link_up unchanged, no speed_change.
5. Lock at 1G, then hold rxc_div constant -> link_up falls 4000 cycles after the last opening edge, link_speed stays 10. Restart toggling every 20 clk -> link_up=1 with link_speed=01 after 2 measurements.
6. Deassert enable mid-measurement, and separately pulse reset_n low between clk edges -> enable: no meas_valid, outputs held. Reset: outputs go to reset values without a clk edge, and the first post-reset edge opens a fresh measurement.
